// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM encoding, grant
// identity and the default response timeout.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_t;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_arbiter_timeout_cnt.sv
// Counts BUSY cycles without a memory completion. expired is high during the
// cycle whose missing ack makes the count reach TIMEOUT.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg;

  // Wait-cycle counter; clear has priority so each transaction starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expired = enable && (cnt_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single registered memory
// port. One transaction in flight; ties go to the side not granted last.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_ack,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BW = DATA_W / 8;

  state_t            state_reg, state_next;
  gnt_t              gnt_reg, gnt_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [BW-1:0]     mem_be_reg, mem_be_next;
  logic              if_ack_reg, if_ack_next, if_err_reg, if_err_next;
  logic              ls_ack_reg, ls_ack_next, ls_err_reg, ls_err_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next, ls_rdata_reg, ls_rdata_next;
  logic              tmo_expired;
  gnt_t              pick;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_reg != ST_BUSY),
    .enable  ((state_reg == ST_BUSY) && !mem_ack),
    .expired (tmo_expired)
  );

  // State and every output register; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= GNT_IF;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      if_ack_reg    <= 1'b0;
      if_err_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      ls_ack_reg    <= 1'b0;
      ls_err_reg    <= 1'b0;
      ls_rdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      if_ack_reg    <= if_ack_next;
      if_err_reg    <= if_err_next;
      if_rdata_reg  <= if_rdata_next;
      ls_ack_reg    <= ls_ack_next;
      ls_err_reg    <= ls_err_next;
      ls_rdata_reg  <= ls_rdata_next;
    end
  end

  // Next-state, arbitration and next register values; acks default to idle.
  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    if_ack_next    = 1'b0;
    if_err_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    ls_ack_next    = 1'b0;
    ls_err_next    = 1'b0;
    ls_rdata_next  = ls_rdata_reg;
    pick           = GNT_IF;
    if (if_req && ls_req) begin
      pick = (gnt_reg == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (ls_req) begin
      pick = GNT_LS;
    end
    case (state_reg)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          state_next   = ST_BUSY;
          gnt_next     = pick;
          mem_req_next = 1'b1;
          if (pick == GNT_LS) begin
            mem_we_next    = ls_we;
            mem_addr_next  = ls_addr;
            mem_wdata_next = ls_wdata;
            mem_be_next    = ls_be;
          end else begin
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr;
            mem_wdata_next = '0;
            mem_be_next    = '1;
          end
        end
      end
      ST_BUSY: begin
        // A completion beats a simultaneous timeout.
        if (mem_ack || tmo_expired) begin
          state_next   = ST_RESP;
          mem_req_next = 1'b0;
          if (gnt_reg == GNT_LS) begin
            ls_ack_next   = 1'b1;
            ls_err_next   = !mem_ack;
            ls_rdata_next = mem_ack ? mem_rdata : '0;
          end else begin
            if_ack_next   = 1'b1;
            if_err_next   = !mem_ack;
            if_rdata_next = mem_ack ? mem_rdata : '0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_reg != ST_IDLE);
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign if_ack    = if_ack_reg;
  assign if_err    = if_err_reg;
  assign if_rdata  = if_rdata_reg;
  assign ls_ack    = ls_ack_reg;
  assign ls_err    = ls_err_reg;
  assign ls_rdata  = ls_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts which
// side is granted, what appears on the memory port and what response follows.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_ack, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_ack, ls_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [BW-1:0] ls_be;
  logic          mem_req, mem_we, mem_ack, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  // Model state: who was granted last (1 = LS) and the held read data.
  bit            m_last_ls;
  logic [DW-1:0] m_if_rdata, m_ls_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic raise_if();
    if_req  = 1'b1;
    if_addr = $urandom & 32'hFFFF_FFFE;
  endtask

  task automatic raise_ls();
    ls_req   = 1'b1;
    ls_we    = 1'($urandom_range(0, 1));
    ls_addr  = $urandom | 32'h1;
    ls_wdata = $urandom;
    ls_be    = 4'($urandom);
  endtask

  // One full transaction starting at an IDLE-cycle negedge with requests
  // driven. Memory acks during BUSY cycle n_ack (1-based); n_ack > TO = never.
  task automatic do_round(input int n_ack, input logic [DW-1:0] rd);
    bit            side_ls;
    bit            exp_err;
    logic [DW-1:0] exp_rd;
    check("idle_busy", busy, 0);
    check("idle_mem_req", mem_req, 0);
    side_ls   = (if_req && ls_req) ? !m_last_ls : ls_req;
    m_last_ls = side_ls;
    @(negedge clk);
    check("grant_mem_req", mem_req, 1);
    check("grant_busy", busy, 1);
    check("mem_we", mem_we, side_ls ? ls_we : 1'b0);
    check("mem_addr", mem_addr, side_ls ? ls_addr : if_addr);
    check("mem_wdata", mem_wdata, side_ls ? ls_wdata : 32'h0);
    check("mem_be", mem_be, side_ls ? ls_be : 4'hF);
    for (int c = 1; c <= TO; c++) begin
      check("wait_mem_req", mem_req, 1);
      check("wait_acks", {if_ack, ls_ack}, 2'b00);
      mem_ack   = (c == n_ack);
      mem_rdata = (c == n_ack) ? rd : $urandom;
      @(negedge clk);
      if (c == n_ack) break;
    end
    mem_ack = 1'b0;
    exp_err = (n_ack > TO);
    exp_rd  = exp_err ? 32'h0 : rd;
    if (side_ls) m_ls_rdata = exp_rd;
    else         m_if_rdata = exp_rd;
    check("resp_if_ack", if_ack, !side_ls);
    check("resp_ls_ack", ls_ack, side_ls);
    check("resp_if_err", if_err, !side_ls && exp_err);
    check("resp_ls_err", ls_err, side_ls && exp_err);
    check("resp_if_rdata", if_rdata, m_if_rdata);
    check("resp_ls_rdata", ls_rdata, m_ls_rdata);
    check("resp_mem_req", mem_req, 0);
    check("resp_busy", busy, 1);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clk);
    // The served request was still high across the RESP edge: must not regrant.
    check("post_acks", {if_ack, ls_ack, if_err, ls_err}, 4'b0000);
    check("post_if_rdata", if_rdata, m_if_rdata);
    check("post_ls_rdata", ls_rdata, m_ls_rdata);
    check("post_mem_req", mem_req, 0);
    check("post_busy", busy, 0);
    if (side_ls) ls_req = 1'b0;
    else         if_req = 1'b0;
    n_txn++;
    $display("txn %0d side=%s ack_cycle=%0d err=%0b rdata=%08h",
             n_txn, side_ls ? "LS" : "IF", n_ack, exp_err, exp_rd);
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    m_last_ls = 1'b0; m_if_rdata = '0; m_ls_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {mem_req, mem_we, busy, if_ack, if_err, ls_ack, ls_err}, 7'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", {if_rdata, ls_rdata}, 64'h0);

    // Both requesters right at reset release: LS wins the first tie.
    rst_n = 1'b1;
    raise_if(); raise_ls(); ls_we = 1'b0;
    do_round(2, $urandom);
    do_round(1, 32'h0000_0013);
    check("if_rdata_13", if_rdata, 32'h0000_0013);

    // Single LS write.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'hF;
    do_round(2, $urandom);

    // Both held continuously: grants alternate.
    raise_if(); raise_ls();
    for (int i = 0; i < 6; i++) begin
      do_round($urandom_range(1, 4), $urandom);
      if (!if_req) raise_if();
      if (!ls_req) raise_ls();
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);

    // Timeout, then ack exactly on the last allowed cycle.
    raise_if();
    do_round(TO + 5, $urandom);
    raise_ls();
    do_round(TO, 32'hCAFE_0015);

    // Asynchronous reset while BUSY.
    raise_if();
    mem_ack = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_busy", busy, 0);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_ack", {if_ack, ls_ack}, 2'b00);
    rst_n = 1'b1;
    m_last_ls = 1'b0; m_if_rdata = '0; m_ls_rdata = '0;
    raise_if();
    do_round(3, $urandom);

    // Random traffic.
    for (int r = 0; r < 40; r++) begin
      if (!if_req && $urandom_range(0, 1) == 1) raise_if();
      if (!ls_req && $urandom_range(0, 1) == 1) raise_ls();
      if (!if_req && !ls_req) begin
        if ($urandom_range(0, 1) == 1) raise_if();
        else raise_ls();
      end
      do_round($urandom_range(1, TO + 3), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
